// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for sync_fifo_param.
//   log2_f     - constant ceil(log2) used to derive the pointer width AW
//   is_pow2    - power-of-two test
//   params_ok  - parameter legality check evaluated at elaboration time
package sync_fifo_pkg;

   function automatic int unsigned log2_f(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_ok(input int unsigned dw, input int unsigned depth,
                                    input int unsigned af, input int unsigned ae);
      return (dw >= 1) && (depth >= 4) && is_pow2(depth) &&
             (af >= 1) && (af <= depth) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port storage, DEPTH x DATA_W.
//   Synchronous write; registered read with read enable. The read register
//   (rdata_o) is reset to 0 and holds its value when re_i is low.
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i           read port
//   rdata_o                registered read data
module sync_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage contents are don't-care after reset, so no reset on the array.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
//   Pointers are AW+1 bits (MSB = wrap bit); count = wptr - rptr, registered.
//   Status flags decode the registered count only. Reads have one cycle of
//   latency: rdata/rvalid appear in the cycle after an accepted rd_en.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wdata        write request / data
//   rd_en               read request
//   rdata, rvalid       registered read data, one-cycle valid pulse
//   full, empty, almost_full, almost_empty, count   occupancy status
//   err_clr, overflow, underflow                     sticky error flags
// Build option: define SYNC_FIFO_ERR_FLAGS_EN to enable overflow/underflow;
//   otherwise they read 0 and err_clr is ignored.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 16,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 2,
   localparam int AW       = log2_f(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AW:0]       count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   generate
      if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
         $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
      end
   endgenerate

   localparam int          DEPTH_I = DEPTH;
   localparam int          AF_I    = AF_LEVEL;
   localparam int          AE_I    = AE_LEVEL;
   localparam logic [AW:0] DEPTH_C = DEPTH_I[AW:0];
   localparam logic [AW:0] AF_C    = AF_I[AW:0];
   localparam logic [AW:0] AE_C    = AE_I[AW:0];

   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic        rvalid_q;
   logic        wr_acc, rd_acc;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign rvalid       = rvalid_q;

   // full/empty gate the requests, so rejected strobes never move state.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_comb begin
      wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
      rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
      // Modulo-2^(AW+1) difference; natural rollover handles wrap.
      count_d = wptr_d - rptr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rvalid_q <= rd_acc;
      end
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (wdata),
      .re_i    (rd_acc),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (rdata)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   // Clear then set, so a new error in the clearing cycle is retained.
   always_comb begin
      ovf_d = (ovf_q & ~err_clr) | (wr_en & full);
      udf_d = (udf_q & ~err_clr) | (rd_en & empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule
